// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction-time measurement block.
// Includes the BCD increment used by the counter and by the best-time capture.
package reaction_timer_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, MEASURE, DONE} state_t;

    localparam logic [15:0] BCD_MAX  = 16'h9999;
    localparam logic [15:0] BCD_ZERO = 16'h0000;

    // Ripple a decimal carry from the units digit upward; 9999 wraps to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reaction_timer_bcd_counter4.sv
// Four-digit BCD up-counter that saturates at MAX; clear has priority over enable.
// One-cycle update latency; value holds whenever enable is low or at_max is set.
module bcd_counter4
    import reaction_timer_pkg::*;
#(
    parameter logic [15:0] MAX = BCD_MAX
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    output logic [15:0] value,
    output logic        at_max
);

    assign at_max = (value == MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= BCD_ZERO;
        end else if (clear) begin
            value <= BCD_ZERO;
        end else if (enable && !at_max) begin
            value <= bcd_inc(value);
        end
    end

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time measurement: lights the stimulus after go and counts ms until a button press.
// Results are registered; the reported time includes the two-cycle synchronizer delay.
module reaction_timer
    import reaction_timer_pkg::*;
#(
    parameter logic [15:0] MAX_BCD = BCD_MAX
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        arm,
    input  logic        go,
    input  logic        button,
    output logic        stimulus,
    output logic        busy,
    output logic [15:0] elapsed,
    output logic        result_valid,
    output logic        early,
    output logic        timeout,
    output logic [15:0] best
);

    logic        sync1;
    logic        sync2;
    logic        prev;
    logic        press;
    state_t      state;
    logic        cnt_clear;
    logic        cnt_enable;
    logic        at_max;
    logic [15:0] final_val;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign press = sync2 & ~prev;

    assign cnt_clear  = arm | ((state == WAIT) & go & ~press);
    assign cnt_enable = (state == MEASURE) & ~arm;

    // The press cycle itself still counts, so the captured time is the counter's next value.
    assign final_val = at_max ? elapsed : bcd_inc(elapsed);

    bcd_counter4 #(
        .MAX (MAX_BCD)
    ) u_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .value  (elapsed),
        .at_max (at_max)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            stimulus     <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            early        <= 1'b0;
            timeout      <= 1'b0;
            best         <= BCD_MAX;
        end else if (arm) begin
            state        <= WAIT;
            stimulus     <= 1'b0;
            busy         <= 1'b1;
            result_valid <= 1'b0;
            early        <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    if (press) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        early        <= 1'b1;
                    end else if (go) begin
                        state    <= MEASURE;
                        stimulus <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (press) begin
                        state        <= DONE;
                        stimulus     <= 1'b0;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        if (final_val < best) begin
                            best <= final_val;
                        end
                    end else if (at_max) begin
                        state        <= DONE;
                        stimulus     <= 1'b0;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        timeout      <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_timer.sv
// Directed and randomized checks of reaction_timer against a millisecond-count reference model.
module tb_reaction_timer;

    logic        clock;
    logic        reset;
    logic        arm;
    logic        go;
    logic        button;
    logic        stimulus;
    logic        busy;
    logic [15:0] elapsed;
    logic        result_valid;
    logic        early;
    logic        timeout;
    logic [15:0] best;

    int checks   = 0;
    int failures = 0;
    int best_ms  = 9999;

    reaction_timer dut (
        .clock        (clock),
        .reset        (reset),
        .arm          (arm),
        .go           (go),
        .button       (button),
        .stimulus     (stimulus),
        .busy         (busy),
        .elapsed      (elapsed),
        .result_valid (result_valid),
        .early        (early),
        .timeout      (timeout),
        .best         (best)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] to_bcd(input int ms);
        int v;
        v = (ms > 9999) ? 9999 : ms;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step(1);
        arm = 1'b0;
    endtask

    // Press raised d cycles after the go edge; the model expects d+2 ms reported.
    task automatic do_round(input int d);
        int expect_ms;
        pulse_arm();
        chk("round_busy", 16'(busy), 16'd1);
        step(2);
        go = 1'b1;
        step(1);
        go = 1'b0;
        chk("round_stim_on", 16'(stimulus), 16'd1);
        chk("round_elapsed0", elapsed, 16'h0000);
        step(d - 1);
        button = 1'b1;
        step(2);
        chk("round_not_done", 16'(result_valid), 16'd0);
        step(1);
        expect_ms = (d + 2 > 9999) ? 9999 : d + 2;
        if (expect_ms < best_ms) best_ms = expect_ms;
        chk("round_valid", 16'(result_valid), 16'd1);
        chk("round_elapsed", elapsed, to_bcd(expect_ms));
        chk("round_flags", {14'd0, early, timeout}, 16'd0);
        chk("round_stim_off", {14'd0, stimulus, busy}, 16'd0);
        chk("round_best", best, to_bcd(best_ms));
        button = 1'b0;
        step(3);
    endtask

    initial begin
        reset  = 1'b1;
        arm    = 1'b0;
        go     = 1'b0;
        button = 1'b0;
        step(3);
        reset = 1'b0;
        step(1);
        chk("reset_elapsed", elapsed, 16'h0000);
        chk("reset_best", best, 16'h9999);
        chk("reset_flags", {11'd0, stimulus, busy, result_valid, early, timeout}, 16'd0);

        // go while idle must not start anything
        go = 1'b1;
        step(1);
        go = 1'b0;
        chk("idle_go_ignored", {14'd0, busy, stimulus}, 16'd0);

        do_round(250);
        do_round(298);
        do_round(197);
        for (int r = 0; r < 4; r++) do_round(int'($urandom_range(1, 600)));

        // early press before go; stimulus must stay dark throughout
        pulse_arm();
        button = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1);
            chk("early_stim_dark", 16'(stimulus), 16'd0);
        end
        step(1);
        chk("early_valid", 16'(result_valid), 16'd1);
        chk("early_flag", 16'(early), 16'd1);
        chk("early_elapsed", elapsed, 16'h0000);
        chk("early_stim", 16'(stimulus), 16'd0);
        chk("early_best", best, to_bcd(best_ms));

        // button still held across a new arm: no fresh edge, so no early flag
        pulse_arm();
        step(4);
        chk("held_no_early", {14'd0, result_valid, early}, 16'd0);
        go = 1'b1;
        step(1);
        go = 1'b0;
        step(5);
        chk("held_measuring", {14'd0, stimulus, result_valid}, 16'b10);
        button = 1'b0;
        step(3);

        // press and go in the same WAIT cycle
        pulse_arm();
        button = 1'b1;
        step(2);
        go = 1'b1;
        step(1);
        go = 1'b0;
        chk("tie_early", {13'd0, result_valid, early, stimulus}, 16'b110);
        go = 1'b1;
        step(1);
        go = 1'b0;
        chk("done_go_ignored", {14'd0, result_valid, stimulus}, 16'b10);
        pulse_arm();
        chk("rearm_flags", {13'd0, busy, result_valid, early}, 16'b100);
        chk("rearm_elapsed", elapsed, 16'h0000);
        button = 1'b0;
        step(3);

        // no press: count through every BCD carry to saturation and timeout
        pulse_arm();
        go = 1'b1;
        step(1);
        go = 1'b0;
        for (int k = 1; k <= 9999; k++) begin
            step(1);
            chk($sformatf("count_%0d", k), elapsed, to_bcd(k));
        end
        chk("count_not_done", 16'(result_valid), 16'd0);
        step(1);
        chk("timeout_flags", {12'd0, result_valid, timeout, early, stimulus}, 16'b1100);
        chk("timeout_elapsed", elapsed, 16'h9999);
        chk("timeout_best", best, to_bcd(best_ms));

        // press landing exactly on the saturated cycle is a valid 9999
        do_round(9998);

        // asynchronous reset mid-measurement clears best too
        pulse_arm();
        go = 1'b1;
        step(1);
        go = 1'b0;
        step(42);
        chk("mid_elapsed", elapsed, 16'h0042);
        #2 reset = 1'b1;
        #1;
        best_ms = 9999;
        chk("arst_elapsed", elapsed, 16'h0000);
        chk("arst_best", best, to_bcd(best_ms));
        chk("arst_flags", {11'd0, stimulus, busy, result_valid, early, timeout}, 16'd0);
        step(2);
        reset = 1'b0;
        step(2);
        chk("post_reset_idle", {14'd0, busy, stimulus}, 16'd0);
        do_round(int'($urandom_range(1, 300)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reaction_timer.md
# reaction_timer

Measures player reaction time in the reaction-time game. After the random-delay countdown signals `go`, the block lights the stimulus and counts 1 kHz clock ticks until the player's button press. It reports the elapsed milliseconds as 4-digit BCD, flags early presses and timeouts, and keeps the best time since reset for the seven-segment display logic.

## Interface
- `MAX_BCD`, 16'h9999: saturation and timeout value of `elapsed`, in BCD.
- `clock`  in  1  1 kHz system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `arm`  in  1  single-cycle pulse that starts a round.
- `go`  in  1  single-cycle pulse from the countdown logic marking the end of the random delay.
- `button`  in  1  raw, asynchronous player button, active-high.
- `stimulus`  out  1  high while measuring; drives the player LED.
- `busy`  out  1  high in WAIT or MEASURE.
- `elapsed`  out  16  four BCD digits, thousands in [15:12].
- `result_valid`  out  1  high in DONE.
- `early`  out  1  high in DONE when the press came before `go`.
- `timeout`  out  1  high in DONE when no press came before saturation.
- `best`  out  16  lowest valid, non-early, non-timeout `elapsed` since reset, in BCD.

## Operation
- Button path:
  - Two-flop synchronizer, then a registered previous value.
  - `press` = synced & ~prev, one cycle per rising edge.
  - A button already held does not generate `press`.
- States and transitions:
  - IDLE: waits for `arm`.
  - WAIT:
    - `press` → DONE with early=1.
    - Otherwise `go` → MEASURE.
  - MEASURE:
    - `press` → DONE, `elapsed` frozen.
    - If `elapsed` == MAX_BCD and no `press` → DONE with timeout=1.
    - Otherwise `elapsed` += 1 as a BCD increment with decimal carry per digit (0009→0010, 0999→1000).
  - DONE: holds all results until `arm`.
- `arm` in any state, reset excepted:
  - Next state WAIT.
  - Clears `elapsed`, `early`, `timeout`.
  - `best` is kept.
  - `arm` has priority over every other input.
- Simultaneous events:
  - In WAIT, `press` and `go` in the same cycle: early wins.
  - In MEASURE, `press` in the cycle `elapsed` == MAX_BCD: a valid result of 9999 with timeout=0.
- `go` outside WAIT and `press` in IDLE/DONE are ignored.
- Best update: on the MEASURE→DONE edge caused by `press`, if `elapsed` < `best`, then `best` ← `elapsed`. Compare as unsigned binary; this is valid for BCD.
- Reset values:
  - State IDLE.
  - `elapsed` 16'h0000, `best` 16'h9999.
  - All flags 0, sync flops 0.
- Reset asserted mid-round returns everything to reset values immediately, `best` included.

## Timing
- `go` sampled at edge N → `stimulus`=1 and `elapsed`=0000 after edge N.
- `elapsed` increments at edges N+1, N+2, …, so it reads k after edge N+k.
- Raw `button` rising before edge P → synced after edge P+1, `press` during the following cycle → DONE after edge P+2.
- The reported time includes this fixed 2-cycle synchronizer latency, uncompensated.
- `result_valid`, `early`, `timeout`, `stimulus`, `busy` are all registered; no combinational path from inputs to outputs.
- `arm` at edge A → `busy`=1 after edge A.

## Structure
- Shared package holds:
  - State enum (IDLE, WAIT, MEASURE, DONE).
  - `BCD_MAX` = 16'h9999.
  - `BCD_ZERO` = 16'h0000.
- Sub-module `bcd_counter4`:
  - Inputs: clear, enable.
  - Outputs: 16-bit BCD value and `at_max`.
  - Per-digit carry chain.
  - Shares the asynchronous reset.
- Synchronizer, edge detector, FSM and best register live in the top.

## Test plan
- Reset mid-MEASURE at `elapsed`=0042 → state IDLE, `elapsed`=0000, `best`=9999, all flags 0.
- arm, go at edge N, raw press before edge N+250 → DONE after edge N+252: `elapsed`=0252, `early`=0, `best`=0252.
- Second round, press after 300 ms → `elapsed`=0300, `best` remains 0252. Third round at 0199 → `best`=0199.
- arm, press before go → DONE with `early`=1, `elapsed`=0000, `stimulus` never 1, `best` unchanged. A button held high across `arm` with no new rising edge does not flag early.
- arm, go, no press → `elapsed` passes 0009→0010, 0099→0100, 0999→1000, then reaches 9999 → DONE with `timeout`=1 one edge later, `elapsed`=9999.
- `press` and `go` in the same WAIT cycle → early=1. `arm` during DONE clears flags and re-enters WAIT.
